// File: rtl/seq_approx_divider.sv
// seq_approx_divider
//   Radix-2 restoring divider, one quotient bit per clock, 2W-bit dividend by
//   W-bit divisor. The subtractor uses approximate cells in a triangular
//   low-order region (column j at iteration k is approximate when
//   j + k < APPROX_BITS). APPROX_BITS = 0 gives an exact divider.
//
// Ports
//   clk    : clock, rising edge
//   rst_n  : asynchronous active-low reset
//   start  : begin a division (accepted when busy = 0)
//   n      : 2W-bit dividend, sampled at accept
//   d      : W-bit divisor, sampled at accept
//   busy   : iteration in progress
//   done   : q/r valid, held until the next accept
//   q      : quotient, truncated to W bits
//   r      : remainder
//   ovf    : n[2W-1:W] >= d, quotient truncated
//   dbz    : divisor was zero
module seq_approx_divider #(
  parameter int unsigned W           = 8,
  parameter int unsigned APPROX_BITS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [2*W-1:0] n,
  input  logic [W-1:0]   d,
  output logic           busy,
  output logic           done,
  output logic [W-1:0]   q,
  output logic [W-1:0]   r,
  output logic           ovf,
  output logic           dbz
);

  localparam int unsigned KW = (W > 2) ? $clog2(W) : 1;
  localparam logic [KW-1:0] KLAST = KW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  rem_q,   rem_d;
  logic [W-1:0]  nlo_q,   nlo_d;
  logic [W-1:0]  div_q,   div_d;
  logic [KW-1:0] k_q,     k_d;
  logic [W-1:0]  quo_q,   quo_d;
  logic          ovf_q,   ovf_d;
  logic          dbz_q,   dbz_d;

  // Datapath for one iteration
  logic          top_bit;
  logic [W-1:0]  low_word;
  logic [W-1:0]  diff_w;
  logic          borrow;
  logic          qbit;
  logic          cx, cy;
  int unsigned   k_int;

  always_comb begin
    top_bit  = rem_q[W-1];
    low_word = {rem_q[W-2:0], nlo_q[k_q]};
    diff_w   = '0;
    borrow   = 1'b0;
    cx       = 1'b0;
    cy       = 1'b0;
    k_int    = 32'(k_q);
    // Ripple-borrow chain, column 0 first; borrow logic is the same for both
    // cell types, only the difference bit changes in the approximate region.
    for (int unsigned j = 0; j < W; j++) begin
      cx = low_word[j];
      cy = div_q[j];
      if (j + k_int < APPROX_BITS) begin
        diff_w[j] = (~cx & cy & ~borrow) | (cx & ~cy);
      end else begin
        diff_w[j] = cx ^ cy ^ borrow;
      end
      borrow = (~cx & cy) | (~(cx ^ cy) & borrow);
    end
    // A set top bit means P >= 2^W > d, so the subtraction always succeeds.
    qbit = top_bit | ~borrow;
  end

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    nlo_d   = nlo_q;
    div_d   = div_q;
    k_d     = k_q;
    quo_d   = quo_q;
    ovf_d   = ovf_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RUN;
          rem_d   = n[2*W-1:W];
          nlo_d   = n[W-1:0];
          div_d   = d;
          k_d     = KLAST;
          quo_d   = '0;
          ovf_d   = (n[2*W-1:W] >= d);
          dbz_d   = (d == '0);
        end
      end
      RUN: begin
        quo_d[k_q] = qbit;
        rem_d      = qbit ? diff_w : low_word;
        if (k_q == '0) begin
          state_d = DONE;
        end else begin
          k_d = k_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      nlo_q   <= '0;
      div_q   <= '0;
      k_q     <= KLAST;
      quo_q   <= '0;
      ovf_q   <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      nlo_q   <= nlo_d;
      div_q   <= div_d;
      k_q     <= k_d;
      quo_q   <= quo_d;
      ovf_q   <= ovf_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign q    = quo_q;
  assign r    = rem_q;
  assign ovf  = ovf_q;
  assign dbz  = dbz_q;

endmodule
